// File: rtl/gst_snd_fifo.sv
// STE DMA sound receiver: requests words over SREQ/SLOAD_N, buffers them in a small FIFO,
// and pops them at the programmed sample rate as signed 8-bit left/right samples.
module gst_snd_fifo #(
  parameter int DEPTH = 4,
  parameter int PRE_W = 11
) (
  input  logic        clk32,
  input  logic        por,
  input  logic        mhz8_en,
  input  logic        sndon,
  input  logic        mono,
  input  logic [1:0]  rate,
  input  logic        sload_n,
  input  logic [15:0] din,
  output logic        sreq,
  output logic [7:0]  sample_l,
  output logic [7:0]  sample_r,
  output logic        sample_stb,
  output logic        underrun,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_WATER = CW'(DEPTH - 1);

  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             byte_ptr_q, byte_ptr_d;
  logic [PRE_W-1:0] pre_q, pre_d, term;
  logic             sload_prev_q, sndon_prev_q, mono_prev_q;
  logic             sreq_q, sreq_d;
  logic [7:0]       sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic             sample_stb_q, sample_stb_d;
  logic             underrun_q, underrun_d, overflow_q, overflow_d;
  logic             load, tick, empty, pop, accept;
  logic [15:0]      head;

  always_comb begin
    case (rate)
      2'd0:    term = PRE_W'(1279);
      2'd1:    term = PRE_W'(639);
      2'd2:    term = PRE_W'(319);
      default: term = PRE_W'(159);
    endcase
  end

  always_comb begin
    load   = sndon & ~sload_n & sload_prev_q;
    empty  = (count_q == '0);
    tick   = sndon & mhz8_en & (pre_q == term);
    // Mono pops only after the second (low) byte of the head word has been played.
    pop    = tick & ~empty & (~mono | byte_ptr_q);
    accept = load & ((count_q != FULL) | pop);
    head   = mem_q[rd_ptr_q];

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    byte_ptr_d   = byte_ptr_q;
    pre_d        = pre_q;
    sreq_d       = 1'b0;
    sample_l_d   = sample_l_q;
    sample_r_d   = sample_r_q;
    sample_stb_d = 1'b0;

    if (!sndon) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      byte_ptr_d = 1'b0;
      pre_d      = '0;
      sample_l_d = '0;
      sample_r_d = '0;
    end else begin
      if (mhz8_en)
        pre_d = (pre_q >= term) ? '0 : pre_q + 1'b1;
      if (tick && !empty) begin
        sample_stb_d = 1'b1;
        if (!mono) begin
          sample_l_d = head[15:8];
          sample_r_d = head[7:0];
        end else if (!byte_ptr_q) begin
          sample_l_d = head[15:8];
          sample_r_d = head[15:8];
          byte_ptr_d = 1'b1;
        end else begin
          sample_l_d = head[7:0];
          sample_r_d = head[7:0];
          byte_ptr_d = 1'b0;
        end
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept)
        wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(accept) - CW'(pop);
      if (mono != mono_prev_q)
        byte_ptr_d = 1'b0;
      // One slot of headroom covers a load the MCU may already have in flight.
      sreq_d = (count_d < HIGH_WATER);
    end

    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (sndon && !sndon_prev_q) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (tick && empty)
        underrun_d = 1'b1;
      if (load && (count_q == FULL) && !pop)
        overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk32) begin
    if (accept)
      mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_ptr_q   <= 1'b0;
      pre_q        <= '0;
      sload_prev_q <= 1'b1;
      sndon_prev_q <= 1'b0;
      mono_prev_q  <= 1'b0;
      sreq_q       <= 1'b0;
      sample_l_q   <= '0;
      sample_r_q   <= '0;
      sample_stb_q <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      byte_ptr_q   <= byte_ptr_d;
      pre_q        <= pre_d;
      sload_prev_q <= sload_n;
      sndon_prev_q <= sndon;
      mono_prev_q  <= mono;
      sreq_q       <= sreq_d;
      sample_l_q   <= sample_l_d;
      sample_r_q   <= sample_r_d;
      sample_stb_q <= sample_stb_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sreq       = sreq_q;
  assign sample_l   = sample_l_q;
  assign sample_r   = sample_r_q;
  assign sample_stb = sample_stb_q;
  assign underrun   = underrun_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_gst_snd_fifo.sv
// Bench for gst_snd_fifo: queue-based sample model checked every cycle, directed scenarios
// with literal expectations, then a randomized MCU/sndon/mono/rate phase.
`timescale 1ns/1ps
module tb_gst_snd_fifo;
  localparam int DEPTH = 4;

  logic        clk32 = 1'b0;
  logic        por = 1'b1;
  logic        mhz8_en = 1'b0;
  logic        sndon = 1'b0;
  logic        mono = 1'b0;
  logic [1:0]  rate = 2'd0;
  logic        sload_n = 1'b1;
  logic [15:0] din = 16'h0;
  logic        sreq, sample_stb, underrun, overflow;
  logic [7:0]  sample_l, sample_r;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_seen = 0;

  // Reference model: a word queue, a byte phase and a divide-by-N period counter.
  logic [15:0] mq[$];
  bit          m_bptr;
  int          m_pre;
  logic [7:0]  m_l, m_r;
  bit          m_stb, m_und, m_ovf, m_sreq;
  bit          p_sload = 1'b1;
  bit          p_sndon = 1'b0;
  bit          p_mono = 1'b0;

  gst_snd_fifo #(.DEPTH(DEPTH), .PRE_W(11)) dut (
    .clk32(clk32), .por(por), .mhz8_en(mhz8_en), .sndon(sndon), .mono(mono),
    .rate(rate), .sload_n(sload_n), .din(din), .sreq(sreq),
    .sample_l(sample_l), .sample_r(sample_r), .sample_stb(sample_stb),
    .underrun(underrun), .overflow(overflow)
  );

  initial forever #15.625 clk32 = ~clk32;

  // 8 MHz enable: every fourth clk32 cycle.
  always @(negedge clk32) begin
    cyc++;
    mhz8_en = (cyc % 4 == 0);
  end

  always @(posedge clk32) begin
    if (!sndon) en_seen = 0;
    else if (mhz8_en) en_seen++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelStep();
    bit load, tick, full_before, popped;
    int term;
    logic [15:0] w;
    if (por) begin
      mq.delete();
      m_bptr = 0; m_pre = 0; m_l = 0; m_r = 0;
      m_stb = 0; m_und = 0; m_ovf = 0; m_sreq = 0;
      p_sload = 1; p_sndon = 0; p_mono = 0;
      return;
    end
    term = (1280 >> rate) - 1;
    load = sndon && !sload_n && p_sload;
    tick = sndon && mhz8_en && (m_pre == term);
    if (sndon && !p_sndon) begin
      m_und = 0;
      m_ovf = 0;
    end
    m_stb = 0;
    if (!sndon) begin
      mq.delete();
      m_bptr = 0; m_pre = 0; m_l = 0; m_r = 0; m_sreq = 0;
    end else begin
      full_before = (mq.size() == DEPTH);
      popped = 0;
      if (mhz8_en) m_pre = (m_pre >= term) ? 0 : m_pre + 1;
      if (tick) begin
        if (mq.size() == 0) m_und = 1;
        else begin
          w = mq[0];
          m_stb = 1;
          if (!mono) begin
            m_l = w[15:8]; m_r = w[7:0]; popped = 1;
          end else if (!m_bptr) begin
            m_l = w[15:8]; m_r = w[15:8]; m_bptr = 1;
          end else begin
            m_l = w[7:0]; m_r = w[7:0]; m_bptr = 0; popped = 1;
          end
          if (popped) void'(mq.pop_front());
        end
      end
      if (load) begin
        if (full_before && !popped) m_ovf = 1;
        else mq.push_back(din);
      end
      if (mono != p_mono) m_bptr = 0;
      m_sreq = (mq.size() < DEPTH - 1);
    end
    p_sload = sload_n;
    p_sndon = sndon;
    p_mono = mono;
  endtask

  always @(posedge clk32) begin
    modelStep();
    #1;
    checkOutput("sreq", sreq, m_sreq);
    checkOutput("sample_l", sample_l, m_l);
    checkOutput("sample_r", sample_r, m_r);
    checkOutput("sample_stb", sample_stb, m_stb);
    checkOutput("underrun", underrun, m_und);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("count", dut.count_q, mq.size());
  end

  // One MCU load strobe carrying word w.
  task automatic applyStimulus(input logic [15:0] w);
    din = w;
    sload_n = 1'b0;
    @(negedge clk32);
    sload_n = 1'b1;
    @(negedge clk32);
  endtask

  task automatic waitSreq(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk32);
      if (sreq) return;
    end
    tests++;
    fails++;
    $display("[TB] FAIL sreq_timeout: got 0, expected 1 within %0d cycles", budget);
  endtask

  task automatic waitStrobe(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk32);
      if (sample_stb) return;
    end
    tests++;
    fails++;
    $display("[TB] FAIL strobe_timeout: got 0, expected 1 within %0d cycles", budget);
  endtask

  task automatic restart(input logic [1:0] r, input logic m);
    sndon = 1'b0;
    rate = r;
    mono = m;
    @(negedge clk32);
    sndon = 1'b1;
  endtask

  initial begin
    logic [15:0] words [3];
    logic stb_seen;
    bit found;
    int r;

    repeat (3) @(negedge clk32);
    por = 1'b0;
    @(negedge clk32);
    checkOutput("reset_sreq", sreq, 0);
    checkOutput("reset_l", sample_l, 0);
    checkOutput("reset_r", sample_r, 0);
    checkOutput("reset_stb", sample_stb, 0);
    checkOutput("reset_underrun", underrun, 0);
    checkOutput("reset_overflow", overflow, 0);
    for (int i = 0; i < 100; i++) applyStimulus(16'hFFFF);
    checkOutput("idle_sreq", sreq, 0);
    checkOutput("idle_count", dut.count_q, 0);

    // Stereo fill and drain.
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
    restart(2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      waitSreq(50);
      applyStimulus(words[i]);
    end
    checkOutput("fill_sreq_low", sreq, 0);
    checkOutput("fill_count", dut.count_q, 3);
    waitStrobe(2000);
    checkOutput("first_stb_en", en_seen, 160);
    checkOutput("first_l", sample_l, 8'h12);
    checkOutput("first_r", sample_r, 8'h34);
    waitStrobe(1000);
    checkOutput("second_stb_en", en_seen, 320);
    checkOutput("second_l", sample_l, 8'h56);
    checkOutput("second_r", sample_r, 8'h78);
    waitStrobe(1000);
    checkOutput("third_l", sample_l, 8'h9A);
    checkOutput("third_r", sample_r, 8'hBC);

    // Underrun: one word, then silence.
    restart(2'd3, 1'b0);
    applyStimulus(16'h4321);
    waitStrobe(1000);
    checkOutput("ur_first_l", sample_l, 8'h43);
    stb_seen = 1'b0;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk32);
      stb_seen |= sample_stb;
      found = (en_seen >= 321);
    end
    checkOutput("ur_period_reached", found, 1);
    checkOutput("ur_no_stb", stb_seen, 0);
    checkOutput("ur_flag", underrun, 1);
    checkOutput("ur_hold_l", sample_l, 8'h43);
    checkOutput("ur_hold_r", sample_r, 8'h21);
    sndon = 1'b0;
    @(negedge clk32);
    checkOutput("ur_sticky_off", underrun, 1);
    sndon = 1'b1;
    @(negedge clk32);
    checkOutput("ur_cleared", underrun, 0);

    // Mono byte ordering at the slowest rate.
    restart(2'd0, 1'b1);
    applyStimulus(16'h80FF);
    waitStrobe(6000);
    checkOutput("mono1_en", en_seen, 1280);
    checkOutput("mono1_l", sample_l, 8'h80);
    checkOutput("mono1_r", sample_r, 8'h80);
    checkOutput("mono1_count", dut.count_q, 1);
    waitStrobe(6000);
    checkOutput("mono2_en", en_seen, 2560);
    checkOutput("mono2_l", sample_l, 8'hFF);
    checkOutput("mono2_r", sample_r, 8'hFF);
    checkOutput("mono2_count", dut.count_q, 0);

    // Overflow, then a load coincident with a tick at full.
    restart(2'd3, 1'b0);
    applyStimulus(16'h1111);
    applyStimulus(16'h2222);
    applyStimulus(16'h3333);
    applyStimulus(16'h4444);
    checkOutput("ovf_not_yet", overflow, 0);
    applyStimulus(16'h5555);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_count", dut.count_q, 4);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk32);
      #1;
      found = (en_seen == 159) && mhz8_en;
    end
    checkOutput("ovf_tick_found", found, 1);
    din = 16'h6666;
    sload_n = 1'b0;
    @(negedge clk32);
    sload_n = 1'b1;
    checkOutput("coinc_stb", sample_stb, 1);
    checkOutput("coinc_l", sample_l, 8'h11);
    checkOutput("coinc_count", dut.count_q, 4);
    checkOutput("coinc_overflow", overflow, 1);
    waitStrobe(1000);
    checkOutput("drain_2", sample_l, 8'h22);
    waitStrobe(1000);
    checkOutput("drain_3", sample_l, 8'h33);
    waitStrobe(1000);
    checkOutput("drain_4", sample_l, 8'h44);
    waitStrobe(1000);
    checkOutput("drain_6_l", sample_l, 8'h66);
    checkOutput("drain_6_r", sample_r, 8'h66);

    // Mid-stream disable with byte_ptr=1 and two words queued.
    restart(2'd3, 1'b1);
    applyStimulus(16'h1357);
    applyStimulus(16'h2468);
    waitStrobe(1000);
    checkOutput("mid_l", sample_l, 8'h13);
    checkOutput("mid_count", dut.count_q, 2);
    @(negedge clk32);
    sndon = 1'b0;
    @(negedge clk32);
    checkOutput("off_count", dut.count_q, 0);
    checkOutput("off_l", sample_l, 0);
    checkOutput("off_r", sample_r, 0);
    checkOutput("off_sreq", sreq, 0);
    sndon = 1'b1;
    applyStimulus(16'hA5C3);
    waitStrobe(1000);
    checkOutput("reon_en", en_seen, 160);
    checkOutput("reon_l", sample_l, 8'hA5);
    checkOutput("reon_r", sample_r, 8'hA5);

    // Randomized MCU behaviour with occasional disables, mono flips and rate changes.
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk32);
      r = $urandom_range(0, 999);
      if (!sload_n) sload_n = 1'b1;
      else if ((sreq && r < 60) || r < 5) begin
        sload_n = 1'b0;
        din = 16'($urandom);
      end
      if (!sndon && r < 20) sndon = 1'b1;
      else if (r == 999) sndon = 1'b0;
      if (r == 998) mono = ~mono;
      if (r == 997) rate = 2'($urandom_range(2, 3));
    end
    sload_n = 1'b1;
    repeat (4) @(negedge clk32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gst_snd_fifo.md
Name: gst_snd_fifo

Overview:
- Shifter-side receiver for STE DMA sound. It sits at the far end of the MCU sound-DMA handshake (SREQ / SLOAD_N).
- Requests words from the MCU and captures each DMA word from the RAM data bus into a small FIFO.
- Pops the FIFO at the programmed sample rate and presents signed 8-bit left/right samples to the audio DAC/mixer path.

Parameters:
DEPTH, 4, FIFO depth in 16-bit words; power of two, >=2.
PRE_W, 11, prescaler counter width; must hold 1279.

Ports:
clk32  in  1  system clock, 32 MHz
por  in  1  asynchronous reset, active high
mhz8_en  in  1  8 MHz clock enable, one clk32 cycle wide
sndon  in  1  sound DMA enabled (from MCU control register)
mono  in  1  1 = mono byte stream, 0 = stereo word stream
rate  in  2  sample rate: 0=6258 Hz, 1=12517 Hz, 2=25033 Hz, 3=50066 Hz
sload_n  in  1  MCU load strobe, active low, synchronous to clk32
din  in  16  RAM data bus, valid while sload_n is low
sreq  out  1  sound DMA request to MCU
sample_l  out  8  left sample, signed
sample_r  out  8  right sample, signed
sample_stb  out  1  one-cycle pulse when sample_l/sample_r update
underrun  out  1  sticky: a sample tick found the FIFO empty
overflow  out  1  sticky: a load arrived with the FIFO full

Behaviour:
- Reset (por=1), asynchronous:
  - FIFO pointers, count, byte pointer and prescaler are cleared.
  - All outputs are 0.
- Load detect:
  - A load is sload_n sampled low on a clk32 edge while it was high on the previous edge. A held-low sload_n counts once.
  - The word is written on that same edge. count is visible as incremented on the next cycle.
- Full FIFO:
  - If a load arrives with count==DEPTH and no pop on the same cycle, the word is dropped and overflow is set.
  - If a pop occurs on the same cycle, the load is accepted and count is unchanged.
- sreq:
  - Registered: sreq <= sndon & (count_next < DEPTH-1).
  - The one slot of headroom absorbs the in-flight load the MCU may already have started.
  - sreq falls one cycle after the load that reaches DEPTH-1.
- Prescaler:
  - Advances only on mhz8_en.
  - Terminal count is 1279/639/319/159 for rate 0/1/2/3.
  - At terminal count it reloads 0 and issues tick (mhz8_en & terminal).
  - A rate change takes effect at the next reload. If the counter already exceeds the new terminal value, it reloads 0 on the next mhz8_en.
- Tick, stereo (mono=0), FIFO not empty:
  - Pop one word: sample_l <= word[15:8], sample_r <= word[7:0].
  - Assert sample_stb for one cycle.
- Tick, mono (mono=1), FIFO not empty:
  - byte_ptr=0: sample_l = sample_r <= head[15:8]; no pop; byte_ptr <= 1.
  - byte_ptr=1: sample_l = sample_r <= head[7:0]; pop; byte_ptr <= 0.
- Latency: outputs and sample_stb change on the clk32 edge following the tick cycle (1 cycle).
- Tick with FIFO empty:
  - Outputs hold and sample_stb stays low.
  - underrun is set; byte_ptr is unchanged.
- Simultaneous load and pop with count==0: the pop fails (underrun set). The load is stored and is not bypassed to the outputs.
- sndon low (level, any cycle, including mid-load):
  - FIFO is flushed (count=0, pointers=0), byte_ptr=0 and prescaler=0.
  - sample_l, sample_r, sreq and sample_stb go to 0 on the next edge. Loads are ignored.
- Sticky flags:
  - underrun and overflow clear only on por or on the rising edge of sndon.
  - underrun is not set while sndon is low.
- mono changing mid-stream: byte_ptr resets to 0 on any mono change. No other flush occurs.
- Arithmetic:
  - FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits and never exceeds DEPTH.

Test Plan:
- Reset/idle: por pulse, sndon=0 -> all outputs 0; 100 sload_n pulses change nothing and sreq stays 0.
- Stereo fill and drain:
  - Stimulus: sndon=1, rate=3, mono=0; the bench answers each sreq with one sload_n and din=0x1234, 0x5678, 0x9ABC.
  - Required: sreq drops after count reaches 3.
  - Required: the first sample_stb comes 160 mhz8_en after sndon with L=0x12, R=0x34.
  - Required: the following ticks give 0x56/0x78, then 0x9A/0xBC.
- Mono ordering: mono=1, rate=0, load 0x80FF -> two strobes 1280 mhz8_en apart with L=R=0x80, then L=R=0xFF; count drops after the second strobe only.
- Underrun: stereo, load 1 word, stop responding -> the second tick produces no strobe, outputs hold the first word's bytes, underrun=1; then sndon 0->1 clears it.
- Overflow/simultaneous: force 4 loads with sreq ignored -> the 5th load (no tick) sets overflow and FIFO contents are unchanged; a load coincident with a tick at count=4 is accepted, count stays 4 and overflow is unchanged.
- Mid-stream disable: drop sndon with 2 words queued and byte_ptr=1 -> next cycle: count=0, outputs 0, sreq 0; re-enable restarts at a full prescaler period with byte_ptr=0.
